// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and
// image-format geometry.
package boot_pkg;

  typedef enum logic [2:0] {
    StHdr,
    StLoad,
    StCsum,
    StDone,
    StErr
  } boot_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned ADDR_STEP      = 4;

endpackage

// File: rtl/boot_byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream. The completed word is
// presented combinationally with the 4th byte so the caller can act on the same edge.
module boot_byte_packer
  import boot_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LastByte = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_q;
  logic [31:0] shreg_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 2'd0;
      shreg_q <= 32'd0;
    end else if (byte_valid_i) begin
      cnt_q   <= cnt_q + 2'd1;
      shreg_q <= {byte_data_i, shreg_q[31:8]};
    end
  end

  // Newest byte is the most significant, so earlier bytes land little-endian.
  assign word_valid_o = byte_valid_i && (cnt_q == LastByte);
  assign word_o       = {byte_data_i, shreg_q[31:8]};

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed, checksummed program image into instruction memory
// and releases the core from reset only after the checksum matches.
module boot_loader
  import boot_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic [63:0] MEM_ADDR,
  output logic [31:0] MEM_DATA,
  output logic        MEM_WR,
  output logic        CORE_RST,
  output logic        DONE,
  output logic        ERR
);

  boot_state_e state_q;
  logic [31:0] idx_q;
  logic [31:0] n_q;
  logic [31:0] sum_q;
  logic [63:0] mem_addr_q;
  logic [31:0] mem_data_q;
  logic        mem_wr_q;

  logic        byte_fire;
  logic        word_valid;
  logic [31:0] word;
  logic [31:0] idx_next;

  assign byte_fire = RX_VALID && RX_READY;
  assign idx_next  = idx_q + 32'd1;

  boot_byte_packer u_packer (
    .clk_i        (CLK),
    .rst_i        (RST),
    .byte_valid_i (byte_fire),
    .byte_data_i  (RX_DATA),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StHdr;
      idx_q      <= 32'd0;
      n_q        <= 32'd0;
      sum_q      <= 32'd0;
      mem_addr_q <= 64'd0;
      mem_data_q <= 32'd0;
      mem_wr_q   <= 1'b0;
    end else begin
      mem_wr_q <= 1'b0;
      if (word_valid) begin
        unique case (state_q)
          StHdr: begin
            n_q <= word;
            if (word > 32'(MAX_WORDS)) begin
              state_q <= StErr;
            end else if (word == 32'd0) begin
              state_q <= StCsum;
            end else begin
              state_q <= StLoad;
            end
          end
          StLoad: begin
            mem_data_q <= word;
            mem_addr_q <= BASE_ADDR + 64'(idx_q) * 64'(ADDR_STEP);
            mem_wr_q   <= 1'b1;
            idx_q      <= idx_next;
            sum_q      <= sum_q + word;
            if (idx_next == n_q) begin
              state_q <= StCsum;
            end
          end
          StCsum: begin
            state_q <= (word == sum_q) ? StDone : StErr;
          end
          default: ;
        endcase
      end
    end
  end

  assign RX_READY = (state_q == StHdr) || (state_q == StLoad) || (state_q == StCsum);
  assign CORE_RST = (state_q != StDone);
  assign DONE     = (state_q == StDone);
  assign ERR      = (state_q == StErr);
  assign MEM_ADDR = mem_addr_q;
  assign MEM_DATA = mem_data_q;
  assign MEM_WR   = mem_wr_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances (base 0 / max 4 words, base 0x400 / max 1024)
// share one byte stream and are compared every cycle against an image-parsing model.
module tb_boot_loader;

  localparam logic [63:0] BASE_A = 64'd0;
  localparam logic [63:0] BASE_B = 64'h400;
  localparam int unsigned MAX_A  = 4;
  localparam int unsigned MAX_B  = 1024;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic        rx_ready [2];
  logic [63:0] mem_addr [2];
  logic [31:0] mem_data [2];
  logic        mem_wr   [2];
  logic        core_rst [2];
  logic        done     [2];
  logic        err      [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model state per instance: bytes accepted since reset, last 4 bytes, count, sum.
  longint      m_cnt     [2];
  logic [31:0] m_lw      [2];
  longint      m_n       [2];
  logic [31:0] m_sum     [2];
  int          m_verdict [2];  // 0 = still receiving, 1 = done, 2 = rejected
  logic        e_wr      [2];
  logic [63:0] e_addr    [2];
  logic [31:0] e_data    [2];

  int          obs_wr   [2];
  logic [63:0] obs_addr [2][16];
  logic [31:0] obs_data [2][16];
  logic [31:0] img      [32];

  boot_loader #(.BASE_ADDR(BASE_A), .MAX_WORDS(MAX_A)) dut_a (
    .CLK(clk), .RST(rst), .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready[0]),
    .MEM_ADDR(mem_addr[0]), .MEM_DATA(mem_data[0]), .MEM_WR(mem_wr[0]),
    .CORE_RST(core_rst[0]), .DONE(done[0]), .ERR(err[0])
  );

  boot_loader #(.BASE_ADDR(BASE_B), .MAX_WORDS(MAX_B)) dut_b (
    .CLK(clk), .RST(rst), .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready[1]),
    .MEM_ADDR(mem_addr[1]), .MEM_DATA(mem_data[1]), .MEM_WR(mem_wr[1]),
    .CORE_RST(core_rst[1]), .DONE(done[1]), .ERR(err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret the accepted byte stream by its position in the image.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_cnt[i] = 0; m_lw[i] = 32'd0; m_n[i] = 0; m_sum[i] = 32'd0; m_verdict[i] = 0;
        e_wr[i] = 1'b0; e_addr[i] = 64'd0; e_data[i] = 32'd0;
      end else begin
        e_wr[i] = 1'b0;
        if (rx_valid && m_verdict[i] == 0) begin
          m_cnt[i]++;
          m_lw[i] = {rx_data, m_lw[i][31:8]};
          if (m_cnt[i] == 4) begin
            m_n[i] = longint'(m_lw[i]);
            if (m_n[i] > longint'((i == 0) ? MAX_A : MAX_B)) m_verdict[i] = 2;
          end else if (m_cnt[i] % 4 == 0) begin
            if (m_cnt[i] <= 4 + 4 * m_n[i]) begin
              e_wr[i]   = 1'b1;
              e_addr[i] = ((i == 0) ? BASE_A : BASE_B) + 64'(m_cnt[i] - 8);
              e_data[i] = m_lw[i];
              m_sum[i]  = m_sum[i] + m_lw[i];
            end
            if (m_cnt[i] == 8 + 4 * m_n[i]) m_verdict[i] = (m_lw[i] == m_sum[i]) ? 1 : 2;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison, sampled mid-period.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("rx_ready%0d", i), 64'(rx_ready[i]), 64'(m_verdict[i] == 0));
        check($sformatf("core_rst%0d", i), 64'(core_rst[i]), 64'(m_verdict[i] != 1));
        check($sformatf("done%0d", i), 64'(done[i]), 64'(m_verdict[i] == 1));
        check($sformatf("err%0d", i), 64'(err[i]), 64'(m_verdict[i] == 2));
        check($sformatf("mem_wr%0d", i), 64'(mem_wr[i]), 64'(e_wr[i]));
        check($sformatf("mem_addr%0d", i), mem_addr[i], e_addr[i]);
        check($sformatf("mem_data%0d", i), 64'(mem_data[i]), 64'(e_data[i]));
        if (mem_wr[i]) begin
          if (obs_wr[i] < 16) begin
            obs_addr[i][obs_wr[i]] = mem_addr[i];
            obs_data[i][obs_wr[i]] = mem_data[i];
          end
          obs_wr[i]++;
        end
      end
    end
  end

  task automatic put(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic put_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) put(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // RST asserted together with a valid byte: reset must win.
  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    obs_wr[0] = 0;
    obs_wr[1] = 0;
  endtask

  // Sends header, img[0..n-1] and checksum (true sum plus csum_delta); ends just after
  // the edge that accepts the last byte.
  task automatic send_image(input int n, input logic [31:0] csum_delta, input int maxgap);
    logic [31:0] s;
    s = 32'd0;
    put_word(32'(n), maxgap);
    for (int k = 0; k < n; k++) begin
      put_word(img[k], maxgap);
      s = s + img[k];
    end
    put_word(s + csum_delta, maxgap);
    idle(1);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_ready"}, 64'(rx_ready[i]), 64'd1);
      check({tag, "_wr"}, 64'(mem_wr[i]), 64'd0);
      check({tag, "_addr"}, mem_addr[i], 64'd0);
      check({tag, "_data"}, 64'(mem_data[i]), 64'd0);
      check({tag, "_core_rst"}, 64'(core_rst[i]), 64'd1);
      check({tag, "_done"}, 64'(done[i]), 64'd0);
      check({tag, "_err"}, 64'(err[i]), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0;
    obs_wr[0] = 0; obs_wr[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check_reset_vals("por");

    // Nominal image.
    img[0] = 32'h00500093; img[1] = 32'h00100113;
    send_image(2, 32'd0, 0);
    check("nom_wr_count", 64'(obs_wr[0]), 64'd2);
    check("nom_addr0", obs_addr[0][0], 64'd0);
    check("nom_data0", 64'(obs_data[0][0]), 64'h00500093);
    check("nom_addr1", obs_addr[0][1], 64'd4);
    check("nom_data1", 64'(obs_data[0][1]), 64'h00100113);
    check("nom_done", 64'(done[0]), 64'd1);
    check("nom_core_rst", 64'(core_rst[0]), 64'd0);

    // Bad checksum 0x006001A7.
    do_reset();
    send_image(2, 32'd1, 0);
    check("bad_wr_count", 64'(obs_wr[0]), 64'd2);
    check("bad_err", 64'(err[0]), 64'd1);
    idle(2);
    check("bad_core_rst", 64'(core_rst[0]), 64'd1);
    check("bad_ready", 64'(rx_ready[0]), 64'd0);

    // Oversize for instance A (N = 5 > 4); instance B accepts it.
    do_reset();
    put_word(32'd5, 0);
    idle(1);
    check("ovs_err", 64'(err[0]), 64'd1);
    check("ovs_ready", 64'(rx_ready[0]), 64'd0);
    for (int k = 0; k < 5; k++) img[k] = $urandom;
    begin
      logic [31:0] s;
      s = 32'd0;
      for (int k = 0; k < 5; k++) begin
        put_word(img[k], 0);
        s = s + img[k];
      end
      put_word(s, 0);
      idle(1);
    end
    check("ovs_wr_a", 64'(obs_wr[0]), 64'd0);
    check("ovs_wr_b", 64'(obs_wr[1]), 64'd5);
    check("ovs_done_b", 64'(done[1]), 64'd1);

    // Empty image, good then bad checksum.
    do_reset();
    send_image(0, 32'd0, 0);
    check("empty_done", 64'(done[0]), 64'd1);
    check("empty_wr", 64'(obs_wr[0]), 64'd0);
    do_reset();
    send_image(0, 32'd1, 0);
    check("empty_err", 64'(err[0]), 64'd1);

    // Gapped stream, N = 3; instance B is based at 0x400.
    do_reset();
    for (int k = 0; k < 3; k++) img[k] = $urandom;
    send_image(3, 32'd0, 5);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("gap_addr%0d", k), obs_addr[1][k], 64'h400 + 64'(4 * k));
      check($sformatf("gap_data%0d", k), 64'(obs_data[1][k]), 64'(img[k]));
    end
    check("gap_done", 64'(done[1]), 64'd1);

    // Reset in the middle of a load, then a full nominal reload.
    foreach (img[k]) img[k] = 32'd0;
    for (int r = 0; r < 2; r++) begin
      do_reset();
      img[0] = 32'h00500093; img[1] = 32'h00100113;
      put_word(32'd2, 0);
      put_word(img[0], 0);
      if (r == 0) idle(0); else put_word(img[1], 0);
      do_reset();
      check_reset_vals($sformatf("mid%0d", r));
      send_image(2, 32'd0, 0);
      check($sformatf("mid%0d_addr0", r), obs_addr[0][0], 64'd0);
      check($sformatf("mid%0d_wr", r), 64'(obs_wr[0]), 64'd2);
      check($sformatf("mid%0d_done", r), 64'(done[0]), 64'd1);
    end

    // Random images: N in 1..8, some corrupted checksums.
    for (int t = 0; t < 8; t++) begin
      int n;
      bit bad;
      n   = int'($urandom_range(8, 1));
      bad = ($urandom_range(2, 0) == 0);
      do_reset();
      for (int k = 0; k < n; k++) img[k] = $urandom;
      send_image(n, bad ? 32'(($urandom_range(255, 1))) : 32'd0, 2);
      check($sformatf("rnd%0d_done_b", t), 64'(done[1]), 64'(!bad));
      check($sformatf("rnd%0d_err_a", t), 64'(err[0]), 64'(bad || n > 4));
      check($sformatf("rnd%0d_wr_b", t), 64'(obs_wr[1]), 64'(n));
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
